// File: rtl/weight_reg_file.sv
// ROWS x COLS register file of signed Q7.24 weights for the linear layer.
// One registered read and one write per cycle; out-of-range accesses read 0 / are dropped.
module weight_reg_file #(
  parameter int unsigned ROWS = 32,
  parameter int unsigned COLS = 32,
  parameter int unsigned DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    row_addr,
  input  logic [4:0]    col_addr,
  output logic [DW-1:0] data_out,
  input  logic          wr_en,
  input  logic [4:0]    wr_row,
  input  logic [4:0]    wr_col,
  input  logic [DW-1:0] wr_data
);

  localparam int unsigned RAW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CAW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [DW-1:0] mem [ROWS][COLS];
  logic          rd_ok_c;
  logic          wr_ok_c;

  // Bounds checks; out-of-range indices never reach the array.
  always_comb begin
    rd_ok_c = (32'(row_addr) < ROWS) && (32'(col_addr) < COLS);
    wr_ok_c = wr_en && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
  end

  // rst_n is active-high despite its name. Nonblocking update gives read-before-write on collisions.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      data_out <= '0;
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int c = 0; c < int'(COLS); c++) begin
          mem[r][c] <= '0;
        end
      end
    end else begin
      data_out <= rd_ok_c ? mem[row_addr[RAW-1:0]][col_addr[CAW-1:0]] : '0;
      if (wr_ok_c) begin
        mem[wr_row[RAW-1:0]][wr_col[CAW-1:0]] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_weight_reg_file.sv
// Directed bench for weight_reg_file: a 32x32 instance plus a 20x20 instance for bounds behaviour.
module tb_weight_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  row_addr;
  logic [4:0]  col_addr;
  logic        wr_en;
  logic [4:0]  wr_row;
  logic [4:0]  wr_col;
  logic [31:0] wr_data;
  logic [31:0] data_out;
  logic [31:0] data_out_s;

  int checks;
  int errors;

  weight_reg_file #(.ROWS(32), .COLS(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .row_addr(row_addr), .col_addr(col_addr),
    .data_out(data_out), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data)
  );

  weight_reg_file #(.ROWS(20), .COLS(20), .DW(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .row_addr(row_addr), .col_addr(col_addr),
    .data_out(data_out_s), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] r, input logic [4:0] c, input logic [31:0] d);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] r, input logic [4:0] c);
    row_addr = r; col_addr = c;
  endtask

  task automatic test_reset();
    logic [4:0]  rr [3];
    logic [4:0]  cc [3];
    rr[0] = 5'd0; cc[0] = 5'd0;
    rr[1] = 5'd5; cc[1] = 5'd7;
    rr[2] = 5'd31; cc[2] = 5'd31;
    checks++;
    if (data_out !== 32'h0) begin
      errors++; $display("FAIL reset_initial got %h exp %h", data_out, 32'h0);
    end
    rst_n = 1'b0;
    do_write(5'd0, 5'd0, 32'hDEADBEEF);
    do_write(5'd5, 5'd7, 32'h01234567);
    do_write(5'd31, 5'd31, 32'h89ABCDEF);
    set_rd(5'd0, 5'd0);
    step();
    checks++;
    if (data_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL reset_preload got %h exp %h", data_out, 32'hDEADBEEF);
    end
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (data_out !== 32'h0) begin
      errors++; $display("FAIL reset_async_clear got %h exp %h", data_out, 32'h0);
    end
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rd(rr[i], cc[i]);
      step();
      checks++;
      if (data_out !== 32'h0) begin
        errors++; $display("FAIL reset_read_%0d got %h exp %h", i, data_out, 32'h0);
      end
    end
  endtask

  task automatic test_write_readback();
    do_write(5'd3, 5'd4, 32'h01000000);
    do_write(5'd19, 5'd31, 32'hFF000000);
    set_rd(5'd3, 5'd4);
    step();
    checks++;
    if (data_out !== 32'h01000000) begin
      errors++; $display("FAIL readback_pos1 got %h exp %h", data_out, 32'h01000000);
    end
    set_rd(5'd19, 5'd31);
    step();
    checks++;
    if (data_out !== 32'hFF000000) begin
      errors++; $display("FAIL readback_neg1 got %h exp %h", data_out, 32'hFF000000);
    end
    // Write at one edge, read the same word with the address applied for the next edge.
    wr_en = 1'b1; wr_row = 5'd7; wr_col = 5'd9; wr_data = 32'h80000001;
    set_rd(5'd3, 5'd4);
    step();
    wr_en = 1'b0;
    set_rd(5'd7, 5'd9);
    step();
    checks++;
    if (data_out !== 32'h80000001) begin
      errors++; $display("FAIL write_latency got %h exp %h", data_out, 32'h80000001);
    end
  endtask

  task automatic test_pipelined_reads();
    for (int c = 0; c < 20; c++) do_write(5'd0, 5'(c), 32'(c + 1));
    row_addr = 5'd0;
    for (int c = 0; c < 20; c++) begin
      col_addr = 5'(c);
      step();
      checks++;
      if (data_out !== 32'(c + 1) || data_out_s !== 32'(c + 1)) begin
        errors++;
        $display("FAIL pipe_col%0d got %h/%h exp %h", c, data_out, data_out_s, 32'(c + 1));
      end
    end
  endtask

  task automatic test_collision();
    do_write(5'd2, 5'd2, 32'hAAAA5555);
    set_rd(5'd2, 5'd2);
    wr_en = 1'b1; wr_row = 5'd2; wr_col = 5'd2; wr_data = 32'h12345678;
    step();
    wr_en = 1'b0;
    checks++;
    if (data_out !== 32'hAAAA5555 || data_out_s !== 32'hAAAA5555) begin
      errors++; $display("FAIL collision_old got %h/%h exp %h", data_out, data_out_s, 32'hAAAA5555);
    end
    step();
    checks++;
    if (data_out !== 32'h12345678 || data_out_s !== 32'h12345678) begin
      errors++; $display("FAIL collision_new got %h/%h exp %h", data_out, data_out_s, 32'h12345678);
    end
  endtask

  task automatic test_out_of_range();
    do_write(5'd3, 5'd3, 32'h5A5A0303);
    do_write(5'd25, 5'd3, 32'hCAFEF00D);
    do_write(5'd3, 5'd25, 32'h00000077);
    set_rd(5'd25, 5'd3);
    step();
    checks++;
    if (data_out_s !== 32'h0) begin
      errors++; $display("FAIL oor_read_row got %h exp %h", data_out_s, 32'h0);
    end
    checks++;
    if (data_out !== 32'hCAFEF00D) begin
      errors++; $display("FAIL big_inrange_25_3 got %h exp %h", data_out, 32'hCAFEF00D);
    end
    set_rd(5'd3, 5'd25);
    step();
    checks++;
    if (data_out_s !== 32'h0) begin
      errors++; $display("FAIL oor_read_col got %h exp %h", data_out_s, 32'h0);
    end
    set_rd(5'd3, 5'd3);
    step();
    checks++;
    if (data_out_s !== 32'h5A5A0303) begin
      errors++; $display("FAIL oor_unchanged got %h exp %h", data_out_s, 32'h5A5A0303);
    end
    // (3,25) would alias linear index 85 = (4,5) in a 20-column array.
    set_rd(5'd4, 5'd5);
    step();
    checks++;
    if (data_out_s !== 32'h0) begin
      errors++; $display("FAIL oor_no_alias got %h exp %h", data_out_s, 32'h0);
    end
  endtask

  task automatic test_mid_reset();
    logic [4:0] rr [5];
    logic [4:0] cc [5];
    rr[0] = 5'd0; cc[0] = 5'd0;
    rr[1] = 5'd3; cc[1] = 5'd4;
    rr[2] = 5'd19; cc[2] = 5'd31;
    rr[3] = 5'd2; cc[3] = 5'd2;
    rr[4] = 5'd1; cc[4] = 5'd1;
    row_addr = 5'd0;
    for (int c = 0; c < 4; c++) begin
      col_addr = 5'(c);
      step();
      checks++;
      if (data_out !== 32'(c + 1)) begin
        errors++; $display("FAIL midrst_sweep%0d got %h exp %h", c, data_out, 32'(c + 1));
      end
    end
    col_addr = 5'd4;
    wr_en = 1'b1; wr_row = 5'd1; wr_col = 5'd1; wr_data = 32'h0BADF00D;
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (data_out !== 32'h0 || data_out_s !== 32'h0) begin
      errors++; $display("FAIL midrst_async got %h/%h exp %h", data_out, data_out_s, 32'h0);
    end
    step();
    wr_en = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_rd(rr[i], cc[i]);
      step();
      checks++;
      if (data_out !== 32'h0) begin
        errors++; $display("FAIL midrst_read%0d got %h exp %h", i, data_out, 32'h0);
      end
    end
    set_rd(5'd3, 5'd3);
    step();
    checks++;
    if (data_out_s !== 32'h0) begin
      errors++; $display("FAIL midrst_small got %h exp %h", data_out_s, 32'h0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    row_addr = '0; col_addr = '0;
    wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    step();
    step();
    test_reset();
    test_write_readback();
    test_pipelined_reads();
    test_collision();
    test_out_of_range();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_reg_file.md
# weight_reg_file

Weight storage for the `linear` layer of the keyword-spotting datapath. It holds a ROWS x COLS matrix of signed 32-bit fixed-point weights in Q7.24 format (1 sign, 7 integer, 24 fractional bits). It returns one weight per cycle, addressed by row and column with one cycle of latency. It also has a single synchronous write port that loads or updates weights.

## Interface
Parameters:
- `ROWS`, default 32, number of matrix rows (1..32).
- `COLS`, default 32, number of matrix columns (1..32).
- `DW`, default 32, weight width in bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-high (asserted = 1). The port name is kept for compatibility with the existing instance.
- `row_addr`  in  5  read row index (the `linear` instance drives `input_addr[9:5]`).
- `col_addr`  in  5  read column index (the `linear` instance drives `input_addr[4:0]`).
- `data_out`  out  DW  registered read data, signed Q7.24.
- `wr_en`  in  1  write strobe; may be tied 0.
- `wr_row`  in  5  write row index.
- `wr_col`  in  5  write column index.
- `wr_data`  in  DW  write data.

## Operation
- Storage is ROWS*COLS words of DW bits.
  - Linear index = row*COLS + col.
  - No state machine; a pure register file.
- Reset, asynchronous while `rst_n` = 1:
  - all storage words cleared to 0;
  - `data_out` cleared to 0.
  - Reset takes effect immediately, independent of `clk`.
  - Reset asserted mid-operation discards pending writes and reads.
- Read, every rising edge when not in reset:
  - `data_out` <= mem[`row_addr`][`col_addr`].
  - Reads are unconditional; there is no read-enable.
- Out-of-range read (`row_addr` >= ROWS or `col_addr` >= COLS): `data_out` <= 0. No aliasing or wrap-around.
- Write, on a rising edge with `wr_en` = 1 and not in reset:
  - mem[`wr_row`][`wr_col`] <= `wr_data`.
  - Out-of-range write addresses: write ignored, storage unchanged.
- Simultaneous read and write to the same address on the same edge: read-before-write. `data_out` returns the old word; the new word is visible from the next read edge.
- Simultaneous read and write to different addresses: both proceed independently.
- No arithmetic is done on the data. Values are stored and returned bit-exact, sign preserved.

## Timing
- Read latency: 1 cycle. Address presented before edge N gives `data_out` valid after edge N, held until edge N+1.
- Write latency: 1 cycle. Word written at edge N is readable by an address presented before edge N+1, with data on `data_out` after edge N+1.
- Throughput: one read and one write per cycle.
- Reset release: the first valid read edge is the first rising edge after `rst_n` falls to 0.
- `data_out` is 0 from reset assertion until the first post-reset edge.

## Test plan
- Reset clear: assert `rst_n`=1 mid-cycle with non-zero contents, then release. `data_out` is 0 immediately; reading (0,0), (5,7) and (31,31) returns 0x00000000.
- Write/readback: write 0x01000000 (+1.0) at (3,4) and 0xFF000000 (-1.0) at (19,31). Reading each returns the same bits exactly one cycle after the address is applied.
- Pipelined reads: sweep `col_addr` 0..19 on consecutive cycles after writing value = col+1 in row 0. `data_out` shows 1,2,...,20, each lagging the address by one cycle.
- Read/write collision: mem(2,2)=0xAAAA5555; same edge applies read (2,2) and write 0x12345678 to (2,2). That edge gives 0xAAAA5555; the next edge gives 0x12345678.
- Out-of-range with ROWS=20, COLS=20: write to (25,3) is ignored; reading (25,3) or (3,25) returns 0; mem(3,3) is unchanged.
- Mid-stream reset: assert reset during a read sweep. `data_out` drops to 0 asynchronously, and all previously written words read 0 after release.
